me_sad_min_select: RTL and testbench
====================================

ME_SAD_MIN_SELECT -- requirements
Module: me_sad_min_select

Interface
REQ-001 SHALL have parameters: MACRO_DIM, 16, macroblock edge in pixels.
REQ-002 SHALL have parameters: SEARCH_DIM, 32, search-window edge in pixels.
REQ-003 SHALL have parameters: SAD_W, 16, SAD width in bits.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin new macroblock search (accepted in IDLE only)
- cand_valid  in  1  candidate SAD present this cycle
- cand_sad  in  SAD_W  candidate SAD
- cand_mvx  in  6  candidate column offset, 0..SEARCH_DIM-MACRO_DIM
- cand_mvy  in  6  candidate row offset, 0..SEARCH_DIM-MACRO_DIM
- cand_last  in  1  qualifies final candidate of the search
- sad_thresh  in  SAD_W  early-termination threshold
- busy  out  1  high in SEARCH
- best_valid  out  1  result available
- best_ready  in  1  consumer accepts result
- best_sad  out  SAD_W  minimum SAD
- best_mvx  out  6  offset of minimum, column
- best_mvy  out  6  offset of minimum, row
- cand_count  out  10  candidates accepted this search
- early_term  out  1  result produced by early termination

Function
REQ-005 SHALL implement FSM states IDLE, SEARCH, DONE.
REQ-006 IDLE: busy=0, best_valid=0; start=1 -> SEARCH next cycle, clearing cand_count to 0, best_sad to all-ones, best_mvx/best_mvy to 0, early_term to 0.
REQ-007 A candidate SHALL be accepted only when state=SEARCH and cand_valid=1; cand_valid in IDLE or DONE is ignored, including the start cycle.
REQ-008 On each accepted candidate, cand_count SHALL increment by 1, saturating at 1023.
REQ-009 The first accepted candidate of a search SHALL always load best_sad/best_mvx/best_mvy, regardless of value.
REQ-010 Later candidates SHALL replace the best only when cand_sad < best_sad (strictly less); on a tie the earlier candidate is kept.
REQ-011 Accepted candidate with cand_last=1 SHALL be compared like any other, then the FSM goes to DONE next cycle; best_valid rises one cycle after the last candidate.
REQ-012 cand_last with cand_valid=0 SHALL be ignored.
REQ-013 DONE: best_valid=1; best_sad, best_mvx, best_mvy, cand_count and early_term stay stable until the handshake.
REQ-014 DONE with best_ready=1 -> IDLE next cycle. Outputs keep their values in IDLE until the next start.
REQ-015 start asserted in SEARCH or DONE SHALL be ignored.
REQ-016 Comparison SHALL be unsigned at SAD_W bits.
REQ-017 Unused state encodings SHALL return to IDLE next cycle.

Reset
REQ-018 rst_n low SHALL asynchronously force state=IDLE, busy=0, best_valid=0, best_sad=all-ones, best_mvx=0, best_mvy=0, cand_count=0, early_term=0.
REQ-019 Reset asserted mid-SEARCH or in DONE SHALL discard the search; no result is presented after release.
REQ-020 After reset release, the first start SHALL be honoured on the first clk edge.

Configuration
REQ-021 Macro ME_EARLY_TERM_EN defined: an accepted candidate with cand_sad <= sad_thresh SHALL be compared per REQ-009/010, then force DONE next cycle with early_term=1; later candidates are ignored.
REQ-022 Macro ME_EARLY_TERM_EN undefined: sad_thresh SHALL be ignored, early_term SHALL be tied 0, and only cand_last ends a search.

Verification
REQ-023 start, then SADs 500,300,300(mv 2,1),700 with cand_last on the fourth -> best_sad=300 at the first-300 mv, cand_count=4, best_valid one cycle after the last candidate.
REQ-024 Single candidate SAD=0xFFFF, mv (5,7), cand_last -> best_sad=0xFFFF, mv (5,7), cand_count=1.
REQ-025 best_ready held low 10 cycles in DONE while cand_valid and start toggle -> outputs unchanged; ready=1 -> IDLE next cycle.
REQ-026 rst_n pulsed low after 3 candidates -> busy=0 and best_valid=0 immediately; cand_count=0, and no result appears.
REQ-027 With ME_EARLY_TERM_EN and sad_thresh=100: SADs 400,90,50 -> DONE after 90, best_sad=90, early_term=1, cand_count=2; without the macro, 50 wins at cand_last.
REQ-028 Start with cand_valid high in the same IDLE cycle -> that candidate is not counted (cand_count excludes it).

Source files
------------

// File: rtl/me_sad_min_select.sv
// Motion-estimation SAD minimum selector: tracks the lowest SAD and its motion vector over one search.
// Optional early termination on a SAD threshold is enabled by defining ME_EARLY_TERM_EN.
module me_sad_min_select #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 32,
    parameter int SAD_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cand_valid,
    input  logic [SAD_W-1:0] cand_sad,
    input  logic [5:0]       cand_mvx,
    input  logic [5:0]       cand_mvy,
    input  logic             cand_last,
    input  logic [SAD_W-1:0] sad_thresh,
    output logic             busy,
    output logic             best_valid,
    input  logic             best_ready,
    output logic [SAD_W-1:0] best_sad,
    output logic [5:0]       best_mvx,
    output logic [5:0]       best_mvy,
    output logic [9:0]       cand_count,
    output logic             early_term
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [9:0] CNT_MAX   = 10'd1023;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_busy;
    logic             r_best_valid;
    logic [SAD_W-1:0] r_best_sad;
    logic [5:0]       r_best_mvx;
    logic [5:0]       r_best_mvy;
    logic [9:0]       r_cand_count;
    logic             r_early_term;

    logic             w_accept;
    logic             w_take;
    logic             w_et_hit;
    logic             w_unused_cfg;

    // Window geometry only documents the legal mv range; no logic depends on it.
    assign w_unused_cfg = (SEARCH_DIM >= MACRO_DIM);

    assign w_accept = (r_state == ST_SEARCH) && cand_valid;
    // The first accepted candidate always loads, so an all-ones SAD still records its vector.
    assign w_take   = w_accept && ((r_cand_count == 10'd0) || (cand_sad < r_best_sad));

`ifdef ME_EARLY_TERM_EN
    assign w_et_hit = w_accept && (cand_sad <= sad_thresh);
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^sad_thresh;
    assign w_et_hit        = 1'b0;
`endif

    // Next-state selection for the IDLE/SEARCH/DONE controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (w_accept && (cand_last || w_et_hit)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_DONE: begin
                if (best_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, status flags and best-candidate datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_best_valid <= 1'b0;
            r_best_sad   <= {SAD_W{1'b1}};
            r_best_mvx   <= 6'd0;
            r_best_mvy   <= 6'd0;
            r_cand_count <= 10'd0;
            r_early_term <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt == ST_SEARCH);
            r_best_valid <= (w_state_nxt == ST_DONE);
            if ((r_state == ST_IDLE) && start) begin
                r_best_sad   <= {SAD_W{1'b1}};
                r_best_mvx   <= 6'd0;
                r_best_mvy   <= 6'd0;
                r_cand_count <= 10'd0;
                r_early_term <= 1'b0;
            end else if (w_accept) begin
                if (r_cand_count != CNT_MAX) begin
                    r_cand_count <= r_cand_count + 10'd1;
                end else begin
                    r_cand_count <= r_cand_count;
                end
                if (w_take) begin
                    r_best_sad <= cand_sad;
                    r_best_mvx <= cand_mvx;
                    r_best_mvy <= cand_mvy;
                end else begin
                    r_best_sad <= r_best_sad;
                end
                if (w_et_hit) begin
                    r_early_term <= 1'b1;
                end else begin
                    r_early_term <= r_early_term;
                end
            end else begin
                r_best_sad <= r_best_sad;
            end
        end
    end

    assign busy       = r_busy;
    assign best_valid = r_best_valid;
    assign best_sad   = r_best_sad;
    assign best_mvx   = r_best_mvx;
    assign best_mvy   = r_best_mvy;
    assign cand_count = r_cand_count;
    assign early_term = r_early_term;

endmodule

// File: tb/tb_me_sad_min_select.sv
// Randomized self-checking bench for me_sad_min_select against a list-based reference model.
// Follows ME_EARLY_TERM_EN the same way as the design build.
module tb_me_sad_min_select;

`ifdef ME_EARLY_TERM_EN
    localparam bit ET_EN = 1'b1;
`else
    localparam bit ET_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cand_valid;
    logic [15:0] cand_sad;
    logic [5:0]  cand_mvx;
    logic [5:0]  cand_mvy;
    logic        cand_last;
    logic [15:0] sad_thresh;
    logic        busy;
    logic        best_valid;
    logic        best_ready;
    logic [15:0] best_sad;
    logic [5:0]  best_mvx;
    logic [5:0]  best_mvy;
    logic [9:0]  cand_count;
    logic        early_term;

    me_sad_min_select #(.MACRO_DIM(16), .SEARCH_DIM(32), .SAD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cand_valid(cand_valid),
        .cand_sad(cand_sad), .cand_mvx(cand_mvx), .cand_mvy(cand_mvy),
        .cand_last(cand_last), .sad_thresh(sad_thresh), .busy(busy),
        .best_valid(best_valid), .best_ready(best_ready), .best_sad(best_sad),
        .best_mvx(best_mvx), .best_mvy(best_mvy), .cand_count(cand_count),
        .early_term(early_term)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] c_sad [0:1099];
    logic [5:0]  c_mvx [0:1099];
    logic [5:0]  c_mvy [0:1099];
    int          n_cand;
    logic [15:0] thr;
    int          hold_cycles;

    logic [15:0] e_sad;
    logic [5:0]  e_mvx;
    logic [5:0]  e_mvy;
    int          e_cnt;
    logic        e_et;
    int          e_stop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: minimum over the accepted list, earliest wins ties, stop at threshold hit if enabled.
    task automatic model();
        int best_i;
        best_i = 0;
        e_et   = 1'b0;
        e_stop = n_cand - 1;
        for (int i = 0; i < n_cand; i++) begin
            if (c_sad[i] < c_sad[best_i]) best_i = i;
            if (ET_EN && (c_sad[i] <= thr)) begin
                e_et   = 1'b1;
                e_stop = i;
                break;
            end
        end
        e_sad = c_sad[best_i];
        e_mvx = c_mvx[best_i];
        e_mvy = c_mvy[best_i];
        e_cnt = (e_stop + 1 > 1023) ? 1023 : e_stop + 1;
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_sad"}, best_sad, e_sad);
        chk({tag, "_mvx"}, best_mvx, e_mvx);
        chk({tag, "_mvy"}, best_mvy, e_mvy);
        chk({tag, "_cnt"}, cand_count, e_cnt);
        chk({tag, "_et"}, early_term, e_et);
    endtask

    task automatic run_search();
        int exp_cnt;
        model();
        // Start cycle carries a valid candidate that must not be accepted.
        start = 1'b1; cand_valid = 1'b1; cand_sad = 16'd0;
        cand_mvx = 6'd33; cand_mvy = 6'd33; cand_last = 1'b0; sad_thresh = thr;
        tick();
        chk("busy_start", busy, 1);
        chk("cnt_clear", cand_count, 0);
        chk("sad_clear", best_sad, 16'hFFFF);
        start = 1'b0;
        for (int i = 0; i <= e_stop; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cand_valid = 1'b0; cand_last = 1'($urandom); cand_sad = 16'd0;
                start = 1'($urandom); best_ready = 1'($urandom);
                tick();
                chk("busy_gap", busy, 1);
            end
            start = 1'b0;
            cand_valid = 1'b1; cand_sad = c_sad[i]; cand_mvx = c_mvx[i]; cand_mvy = c_mvy[i];
            cand_last = (i == n_cand - 1);
            tick();
            exp_cnt = (i + 1 > 1023) ? 1023 : i + 1;
            chk("cnt_run", cand_count, exp_cnt);
            if (i < e_stop) chk("busy_run", busy, 1);
            else chk("valid_rise", best_valid, 1);
        end
        cand_valid = 1'b0; cand_last = 1'b0; best_ready = 1'b0;
        chk_result("done");
        for (int k = 0; k < hold_cycles; k++) begin
            cand_valid = 1'($urandom); start = 1'($urandom); cand_last = 1'b1;
            cand_sad = 16'd0; cand_mvx = 6'd1; cand_mvy = 6'd1;
            tick();
            chk("hold_valid", best_valid, 1);
            chk("hold_busy", busy, 0);
            chk_result("hold");
        end
        start = 1'b0; cand_valid = 1'b0; cand_last = 1'b0; best_ready = 1'b1;
        tick();
        best_ready = 1'b0;
        chk("ack_valid", best_valid, 0);
        chk("ack_busy", busy, 0);
        chk_result("idle");
        cand_valid = 1'b1; cand_sad = 16'd0;
        tick();
        cand_valid = 1'b0;
        chk("idle_cnt", cand_count, e_cnt);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cand_valid = 1'b0; cand_sad = 16'd0;
        cand_mvx = 6'd0; cand_mvy = 6'd0; cand_last = 1'b0; sad_thresh = 16'd0;
        best_ready = 1'b0; thr = 16'd0; hold_cycles = 2;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", best_valid, 0);
        chk("rst_sad", best_sad, 16'hFFFF);
        chk("rst_cnt", cand_count, 0);
        chk("rst_et", early_term, 0);
        rst_n = 1'b1;

        // Basic min with a tie: first 300 keeps its vector.
        n_cand = 4; thr = 16'd0; hold_cycles = 2;
        c_sad[0] = 16'd500; c_mvx[0] = 6'd0; c_mvy[0] = 6'd0;
        c_sad[1] = 16'd300; c_mvx[1] = 6'd2; c_mvy[1] = 6'd1;
        c_sad[2] = 16'd300; c_mvx[2] = 6'd9; c_mvy[2] = 6'd9;
        c_sad[3] = 16'd700; c_mvx[3] = 6'd4; c_mvy[3] = 6'd4;
        run_search();
        chk("d023_sad", best_sad, 16'd300);
        chk("d023_mvx", best_mvx, 6'd2);
        chk("d023_mvy", best_mvy, 6'd1);
        chk("d023_cnt", cand_count, 10'd4);

        // Single all-ones candidate still loads; long hold in DONE.
        n_cand = 1; hold_cycles = 10;
        c_sad[0] = 16'hFFFF; c_mvx[0] = 6'd5; c_mvy[0] = 6'd7;
        run_search();
        chk("d024_mvx", best_mvx, 6'd5);
        chk("d024_mvy", best_mvy, 6'd7);
        chk("d024_cnt", cand_count, 10'd1);

        // Threshold behaviour depends on build.
        n_cand = 3; thr = 16'd100; hold_cycles = 3;
        c_sad[0] = 16'd400; c_mvx[0] = 6'd1; c_mvy[0] = 6'd2;
        c_sad[1] = 16'd90;  c_mvx[1] = 6'd3; c_mvy[1] = 6'd4;
        c_sad[2] = 16'd50;  c_mvx[2] = 6'd5; c_mvy[2] = 6'd6;
        run_search();
        chk("d027_sad", best_sad, ET_EN ? 16'd90 : 16'd50);
        chk("d027_et", early_term, ET_EN ? 1 : 0);
        chk("d027_cnt", cand_count, ET_EN ? 10'd2 : 10'd3);

        // Reset mid-search discards everything immediately.
        start = 1'b1; sad_thresh = 16'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cand_valid = 1'b1; cand_sad = 16'(1000 - 100 * i); cand_mvx = 6'(i); cand_mvy = 6'(i);
            tick();
        end
        cand_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", best_valid, 0);
        chk("arst_cnt", cand_count, 0);
        chk("arst_sad", best_sad, 16'hFFFF);
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cand_valid = 1'($urandom); cand_last = 1'b1; best_ready = 1'($urandom);
            tick();
            chk("post_rst_valid", best_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        cand_valid = 1'b0; cand_last = 1'b0; best_ready = 1'b0;

        // Count saturation.
        n_cand = 1030; thr = 16'd0; hold_cycles = 1;
        for (int i = 0; i < n_cand; i++) begin
            c_sad[i] = 16'($urandom_range(200, 65535));
            c_mvx[i] = 6'($urandom_range(0, 16));
            c_mvy[i] = 6'($urandom_range(0, 16));
        end
        run_search();
        chk("sat_cnt", cand_count, ET_EN ? e_cnt : 1023);

        // Random searches, alternating tie-heavy and full-range SADs.
        for (int t = 0; t < 40; t++) begin
            n_cand = $urandom_range(1, 20);
            thr = (t % 2 == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            hold_cycles = $urandom_range(0, 4);
            for (int i = 0; i < n_cand; i++) begin
                c_sad[i] = (t % 2 == 0) ? 16'($urandom_range(0, 15) * 50) : 16'($urandom);
                c_mvx[i] = 6'($urandom_range(0, 16));
                c_mvy[i] = 6'($urandom_range(0, 16));
            end
            run_search();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
